// File: rtl/dac_tx_if.sv
// Transmit-side DAC interface: buffers 4-bit I/Q pairs from the MSK modulator in a
// small FIFO and paces them to a dual 4-bit DAC with a one-cycle load strobe.
module dac_tx_if #(
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4,
    parameter int DIV     = 4
) (
    input  logic                       inClock,
    input  logic                       inReset,
    input  logic [3:0]                 inSinI,
    input  logic [3:0]                 inSinQ,
    input  logic                       inValid,
    output logic                       outReady,
    input  logic                       inEnable,
    input  logic                       inDacBusy,
    input  logic                       inClearErr,
    output logic [3:0]                 outDacI,
    output logic [3:0]                 outDacQ,
    output logic                       outDacLoad,
    output logic [$clog2(DEPTH):0]     outLevel,
    output logic                       outOverflow,
    output logic                       outUnderflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);

    typedef enum logic [2:0] {
        sIdle,
        sPrefill,
        sSetup,
        sLoad,
        sHold
    } state_t;

    state_t         state;
    state_t         nextState;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [LW-1:0]  level;
    logic [CW-1:0]  holdCnt;
    logic           push;
    logic           pop;
    logic           overflowEvt;
    logic           underflowEvt;

    assign outReady   = (level < LW'(DEPTH));
    assign outLevel   = level;
    assign outDacLoad = (state == sLoad);

    // A pair offered while full is still taken if the same edge pops, so the
    // occupancy stays at DEPTH and nothing is dropped.
    assign push        = inValid && (outReady || pop);
    assign overflowEvt = inValid && !push;

    always_comb begin
        nextState    = state;
        pop          = 1'b0;
        underflowEvt = 1'b0;
        case (state)
            sIdle: begin
                if (inEnable) nextState = sPrefill;
            end
            sPrefill: begin
                if (!inEnable)                  nextState = sIdle;
                else if (level >= LW'(PREFILL)) nextState = sSetup;
            end
            sSetup: begin
                if (!inDacBusy) begin
                    nextState = sLoad;
                    if (level != '0) pop = 1'b1;
                    else             underflowEvt = 1'b1;
                end
            end
            sLoad: begin
                nextState = sHold;
            end
            sHold: begin
                if (holdCnt == CW'(DIV - 3)) nextState = inEnable ? sSetup : sIdle;
            end
            default: nextState = sIdle;
        endcase
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state   <= sIdle;
            holdCnt <= '0;
        end else begin
            state   <= nextState;
            holdCnt <= (state == sHold) ? holdCnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge inClock) begin
        if (push) mem[wrPtr] <= {inSinI, inSinQ};
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            outDacI <= '0;
            outDacQ <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr              <= rdPtr + 1'b1;
                {outDacI, outDacQ} <= mem[rdPtr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            outOverflow  <= 1'b0;
            outUnderflow <= 1'b0;
        end else begin
            if (overflowEvt)     outOverflow <= 1'b1;
            else if (inClearErr) outOverflow <= 1'b0;
            if (underflowEvt)    outUnderflow <= 1'b1;
            else if (inClearErr) outUnderflow <= 1'b0;
        end
    end

endmodule
